// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle for pipe_skid_stage: producer side, consumer side and debug status.
// The master modport is the environment (producer and consumer); the slave modport is the stage.
interface pipe_skid_stage_if #(
    parameter int N  = 64,
    parameter int CW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] xfer_count;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy, xfer_count
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy, xfer_count
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// Two-entry elastic (skid) pipeline stage with a wrapping delivered-word counter.
// in_ready depends only on registered state and reset, so back-pressure never forms a combinational loop.
module pipe_skid_stage #(
    parameter int N  = 64,
    parameter int CW = 32
) (
    input  logic             clk,
    input  logic             reset,
    pipe_skid_stage_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [N-1:0]  main_r;
    logic [N-1:0]  skid_r;
    logic [N-1:0]  main_next_s;
    logic [N-1:0]  skid_next_s;
    logic [CW-1:0] count_r;
    logic          in_ready_s;
    logic          out_valid_s;
    logic          push_s;
    logic          pop_s;

    assign in_ready_s  = (state_r != TWO) & reset;
    assign out_valid_s = (state_r != EMPTY);
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.out_ready;

    // Next-state and data-register selection; flush wins over any push.
    always_comb begin
        next_state_s = state_r;
        main_next_s  = main_r;
        skid_next_s  = skid_r;
        if (bus.flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        next_state_s = ONE;
                        main_next_s  = bus.in_data;
                    end else begin
                        next_state_s = EMPTY;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        next_state_s = ONE;
                        main_next_s  = bus.in_data;
                    end else if (push_s) begin
                        next_state_s = TWO;
                        skid_next_s  = bus.in_data;
                    end else if (pop_s) begin
                        next_state_s = EMPTY;
                    end else begin
                        next_state_s = ONE;
                    end
                end
                TWO: begin
                    // No push can occur here because in_ready is low.
                    if (pop_s) begin
                        next_state_s = ONE;
                        main_next_s  = skid_r;
                    end else begin
                        next_state_s = TWO;
                    end
                end
                default: begin
                    next_state_s = EMPTY;
                end
            endcase
        end
    end

    // State and data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= EMPTY;
            main_r  <= {N{1'b0}};
            skid_r  <= {N{1'b0}};
        end else begin
            state_r <= next_state_s;
            main_r  <= main_next_s;
            skid_r  <= skid_next_s;
        end
    end

    // Delivered-word counter; a pop coinciding with flush still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CW{1'b0}};
        end else if (pop_s) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_data   = main_r;
    assign bus.occupancy  = state_r;
    assign bus.xfer_count = count_r;

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Two-entry elastic pipeline register that carries an N-bit word between a producer and a consumer using valid/ready handshakes. It sits directly downstream of the plain `flopr` register. It turns the free-running register output into a back-pressurable stage, so a stalled consumer never drops or duplicates data and `in_ready` never depends combinationally on `out_ready`. It also keeps a wrapping count of delivered words for bench and debug visibility.

## Interface
- `N`, default 64: data width in bits.
- `CW`, default 32: width of the delivered-word counter.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low. `reset = 0` clears all state immediately, regardless of `clk`.
- `in_valid`  in  1: producer offers `in_data` this cycle.
- `in_ready`  out  1: stage can accept a word this cycle.
- `in_data`  in  N: producer word.
- `flush`  in  1: synchronous discard of all held words.
- `out_valid`  out  1: `out_data` holds a valid word.
- `out_ready`  in  1: consumer takes the word this cycle.
- `out_data`  out  N: oldest held word.
- `occupancy`  out  2: number of held words, 0 to 2.
- `xfer_count`  out  CW: number of output transfers since reset, wrapping.

## Operation
- Storage:
  - `main` register drives `out_data`.
  - `skid` register holds a second word.
  - State is EMPTY (0 words), ONE (`main` valid) or TWO (`main` and `skid` valid).
- Transfer definitions:
  - Input transfer (push) = `in_valid & in_ready` at a rising edge.
  - Output transfer (pop) = `out_valid & out_ready` at a rising edge.
- Outputs decoded from state:
  - `in_ready = (state != TWO) & reset`.
  - `out_valid = (state != EMPTY)`.
  - `occupancy` = 0, 1 or 2 for EMPTY, ONE, TWO.
- Transitions when `flush = 0`:
  - EMPTY: push → ONE, `main <= in_data`.
  - ONE, push only: → TWO, `skid <= in_data`.
  - ONE, pop only: → EMPTY.
  - ONE, push and pop together: stay ONE, `main <= in_data`.
  - TWO, pop: → ONE, `main <= skid`. No push is possible in TWO because `in_ready = 0`.
  - No push and no pop: state and data registers hold.
- Flush:
  - `flush = 1` at an edge sets state to EMPTY.
  - Any simultaneous push is discarded.
  - Any simultaneous pop is still counted, because the consumer has already sampled `out_data`.
- Ordering: words leave in exactly the order accepted. No word is lost or duplicated except by flush.
- Counter:
  - `xfer_count` increments by 1 on every pop.
  - Wraps from 2^CW−1 to 0.
  - Unaffected by flush.
- Data registers are not cleared by flush. `out_data` is don't-care whenever `out_valid = 0`.
- Reset (`reset = 0`):
  - State goes to EMPTY; `main`, `skid` and `xfer_count` go to 0.
  - `out_valid = 0`, `in_ready = 0`, `occupancy = 0`, `out_data = 0`.
  - Asserting reset mid-operation drops held words immediately, without waiting for a clock edge.
  - `in_ready` rises in the same cycle that `reset` returns to 1.

## Timing
- Latency: a word pushed at edge k appears on `out_data` with `out_valid = 1` after edge k, i.e. one cycle, when the stage was EMPTY.
- Throughput: one word per cycle sustained while `out_ready = 1`.
- `in_ready` is a pure function of registered state and `reset`. There is no combinational path from `out_ready` to `in_ready`.
- `out_data` is driven directly by the `main` register. There is no combinational path from `in_data`.
- Back-pressure: after `out_ready` falls, at most one further word is accepted (into `skid`). `in_ready` is 0 from the following cycle.
- Inputs are sampled on the rising edge. The bench drives inputs on the falling edge, matching the existing team benches (10 ns period, 5 ns half-period).

## Test plan
- Reset: hold `reset = 0` for 3 cycles with `in_valid = 1` → `out_valid = 0`, `in_ready = 0`, `occupancy = 0`, `xfer_count = 0`. After release, `in_ready = 1` in the same cycle.
- Streaming: push 10 words `64'hAAAA_AAAA_AAAA_AAA0`, `…AAA1`, … `…AAA9` with `out_ready = 1` throughout → each word appears one cycle after it is pushed, in order, and `xfer_count = 10`.
- Stall and fill: with `out_ready = 0`, push `…AAAB`, `…AAAC`, `…AAAD` on consecutive cycles → `occupancy = 2`, `in_ready = 0` after the second push, and `…AAAD` is not accepted. Then raise `out_ready` → `…AAAB` then `…AAAC` are delivered, and `in_ready` returns to 1 after the first pop.
- Simultaneous push and pop in ONE: `occupancy` stays 1 and `out_data` changes to the new word on the next cycle.
- Flush: flush in TWO with `in_valid = 1` → next cycle `occupancy = 0`, `out_valid = 0`, and the pushed word never appears. `xfer_count` is unchanged unless a pop coincided with the flush.
- Asynchronous reset mid-stream: drop `reset` between clock edges while in TWO → `out_valid = 0` and `xfer_count = 0` before the next edge. The stream restarts cleanly after release. Counter wrap is checked separately with `CW = 4`: 17 pops → `xfer_count = 1`.
